// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the instruction-decode stage.
//   - MIPS opcode / funct encodings supported by the decoder
//   - alu_op_e: 4-bit ALU operation code handed to execute
//   - id_ctrl_t: decoded control bundle
//   - decode_inst(): pure combinational decoder for one instruction word
package id_pkg;

  localparam int          REG_AW   = 5;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll r0,r0,0

  // Opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (inst[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ADD is code 0 so an idle / reset stage presents an all-zero alu_op.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [REG_AW-1:0] dest_addr;
    logic [31:0]       imm_ext;
    alu_op_e           alu_op;
    logic              alu_src_imm;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_we;
    logic              branch_eq;
    logic              branch_ne;
    logic              jump;
    logic              illegal;
  } id_ctrl_t;

  // Decode one instruction word, ignoring validity. Unsupported encodings
  // come back with illegal set and every side-effect control cleared.
  function automatic id_ctrl_t decode_inst(input logic [31:0] inst);
    id_ctrl_t c;
    c.dest_addr   = '0;
    c.imm_ext     = {{16{inst[15]}}, inst[15:0]};
    c.alu_op      = ALU_ADD;
    c.alu_src_imm = 1'b0;
    c.reg_we      = 1'b0;
    c.mem_rd      = 1'b0;
    c.mem_we      = 1'b0;
    c.branch_eq   = 1'b0;
    c.branch_ne   = 1'b0;
    c.jump        = 1'b0;
    c.illegal     = 1'b0;

    case (inst[31:26])
      OP_RTYPE: begin
        case (inst[5:0])
          FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:          c.alu_op = ALU_AND;
          FN_OR:           c.alu_op = ALU_OR;
          FN_XOR:          c.alu_op = ALU_XOR;
          FN_NOR:          c.alu_op = ALU_NOR;
          FN_SLT:          c.alu_op = ALU_SLT;
          FN_SLL:          c.alu_op = ALU_SLL;
          FN_SRL:          c.alu_op = ALU_SRL;
          default:         c.illegal = 1'b1;
        endcase
        if (!c.illegal) begin
          c.reg_we    = 1'b1;
          c.dest_addr = inst[15:11];
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.alu_src_imm = 1'b1;
        c.reg_we      = 1'b1;
        c.dest_addr   = inst[20:16];
        case (inst[31:26])
          OP_ANDI: begin c.alu_op = ALU_AND; c.imm_ext = {16'h0, inst[15:0]}; end
          OP_ORI:  begin c.alu_op = ALU_OR;  c.imm_ext = {16'h0, inst[15:0]}; end
          OP_XORI: begin c.alu_op = ALU_XOR; c.imm_ext = {16'h0, inst[15:0]}; end
          OP_LUI:  begin c.alu_op = ALU_LUI; c.imm_ext = {inst[15:0], 16'h0}; end
          default: c.alu_op = ALU_ADD;  // addi
        endcase
      end
      OP_LW: begin
        c.alu_src_imm = 1'b1;
        c.reg_we      = 1'b1;
        c.mem_rd      = 1'b1;
        c.dest_addr   = inst[20:16];
      end
      OP_SW: begin
        c.alu_src_imm = 1'b1;
        c.mem_we      = 1'b1;
      end
      OP_BEQ: begin
        c.alu_op    = ALU_SUB;
        c.branch_eq = 1'b1;
      end
      OP_BNE: begin
        c.alu_op    = ALU_SUB;
        c.branch_ne = 1'b1;
      end
      OP_J:    c.jump    = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREG x 32 register file for the decode stage.
//   Ports: clk, rst (async, active-high)
//          wb_we / wb_addr / wb_data  - synchronous write port (from WB)
//          rs_addr / rt_addr          - async read addresses
//          rs_data / rt_data          - async read data
//   Register 0 is hardwired to zero; writes to it are dropped.
//   Optional macro ID_WB_BYPASS_EN: a write in flight this cycle is
//   forwarded to a matching read port combinationally.
module id_regfile
  import id_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [31:0]       rs_data,
  output logic [31:0]       rt_data
);

  logic [31:0] regs [NREG];
  logic        wr_en;

  assign wr_en = wb_we && (wb_addr != '0);

  // NOTE: the whole array is reset because the architecture promises every
  // register reads 0 after reset; this rules out a RAM macro, which is fine
  // at 32 entries.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  logic [31:0] rs_stored, rt_stored;

  assign rs_stored = (rs_addr == '0) ? '0 : regs[rs_addr];
  assign rt_stored = (rt_addr == '0) ? '0 : regs[rt_addr];

`ifdef ID_WB_BYPASS_EN
  // wr_en already excludes r0, so a zero read address never forwards.
  assign rs_data = (wr_en && (wb_addr == rs_addr)) ? wb_data : rs_stored;
  assign rt_data = (wr_en && (wb_addr == rt_addr)) ? wb_data : rt_stored;
`else
  assign rs_data = rs_stored;
  assign rt_data = rt_stored;
`endif

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage.
//   Inputs : clk, rst (async, active-high), inst_in/pc_in/in_valid from
//            fetch, stall/flush latch control, wb_we/wb_addr/wb_data
//            register-file write port.
//   Outputs: id_valid, id_pc, rs_addr, rt_addr, dest_addr, rs_data,
//            rt_data, imm_ext, alu_op, alu_src_imm, reg_we, mem_rd, mem_we,
//            branch_eq, branch_ne, jump, illegal.
//   The IF/ID latch is the only pipeline register; decode and register
//   reads are combinational from it (one cycle inst_in -> outputs).
//   Optional macro ID_WB_BYPASS_EN enables same-cycle WB write-through
//   inside id_regfile.
module id_stage
  import id_pkg::*;
#(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  dest_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        jump,
  output logic        illegal
);

  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        valid_q;

  // IF/ID latch. Flush beats stall so a redirect is never lost behind a
  // back-pressure cycle; the PC is left alone on flush since it is dead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (flush) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (!stall) begin
      inst_q  <= inst_in;
      pc_q    <= pc_in;
      valid_q <= in_valid;
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = pc_q;
  assign rs_addr  = inst_q[25:21];
  assign rt_addr  = inst_q[20:16];

  id_ctrl_t ctrl;

  // NOTE: every output of this block gets a value before any condition,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    ctrl = decode_inst(inst_q);
    // A bubble must not cause side effects; alu_op / alu_src_imm are also
    // parked at zero so an idle stage presents a clean all-zero bundle.
    if (!valid_q) begin
      ctrl.alu_op      = ALU_ADD;
      ctrl.alu_src_imm = 1'b0;
      ctrl.reg_we      = 1'b0;
      ctrl.mem_rd      = 1'b0;
      ctrl.mem_we      = 1'b0;
      ctrl.branch_eq   = 1'b0;
      ctrl.branch_ne   = 1'b0;
      ctrl.jump        = 1'b0;
      ctrl.illegal     = 1'b0;
    end
  end

  assign dest_addr   = ctrl.dest_addr;
  assign imm_ext     = ctrl.imm_ext;
  assign alu_op      = ctrl.alu_op;
  assign alu_src_imm = ctrl.alu_src_imm;
  assign reg_we      = ctrl.reg_we;
  assign mem_rd      = ctrl.mem_rd;
  assign mem_we      = ctrl.mem_we;
  assign branch_eq   = ctrl.branch_eq;
  assign branch_ne   = ctrl.branch_ne;
  assign jump        = ctrl.jump;
  assign illegal     = ctrl.illegal;

  id_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed, table-driven bench for id_stage plus hand-written
// sequences for register-file, stall/flush, bypass and async-reset cases.
// Inputs change just after the falling edge; outputs are sampled on the
// next falling edge (or #1 after an async event).
module tb_id_stage;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_in, pc_in;
  logic        in_valid, stall, flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  rs_addr, rt_addr, dest_addr;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [3:0]  alu_op;
  logic        alu_src_imm, reg_we, mem_rd, mem_we;
  logic        branch_eq, branch_ne, jump, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst),
    .inst_in(inst_in), .pc_in(pc_in), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dest_addr(dest_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_we(reg_we),
    .mem_rd(mem_rd), .mem_we(mem_we),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump),
    .illegal(illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src, we, mrd, mwe, beq, bne, j, ill;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {id_valid, dest, alu_op, src, we, mrd, mwe, beq, bne, j, ill, imm}
  function automatic logic [63:0] dut_bundle();
    return {14'h0, id_valid, dest_addr, alu_op, alu_src_imm, reg_we, mem_rd, mem_we,
            branch_eq, branch_ne, jump, illegal, imm_ext};
  endfunction

  function automatic logic [63:0] vec_bundle(input vec_t v);
    return {14'h0, v.valid, v.dest, v.alu, v.src, v.we, v.mrd, v.mwe,
            v.beq, v.bne, v.j, v.ill, v.imm};
  endfunction

  logic [63:0] held;

  initial begin
    // inst, valid, dest, imm, alu, src, we, mrd, mwe, beq, bne, j, ill
    vecs[0]  = '{32'h2009_FFFF, 1, 5'd9, 32'hFFFF_FFFF, ALU_ADD, 1,1,0,0,0,0,0,0}; // addi $9,$0,-1
    vecs[1]  = '{32'h0003_2020, 1, 5'd4, 32'h0000_2020, ALU_ADD, 0,1,0,0,0,0,0,0}; // add $4,$0,$3
    vecs[2]  = '{32'h0022_2822, 1, 5'd5, 32'h0000_2822, ALU_SUB, 0,1,0,0,0,0,0,0}; // sub $5,$1,$2
    vecs[3]  = '{32'h0064_102A, 1, 5'd2, 32'h0000_102A, ALU_SLT, 0,1,0,0,0,0,0,0}; // slt $2,$3,$4
    vecs[4]  = '{32'h0003_1102, 1, 5'd2, 32'h0000_1102, ALU_SRL, 0,1,0,0,0,0,0,0}; // srl $2,$3,4
    vecs[5]  = '{32'h3406_8001, 1, 5'd6, 32'h0000_8001, ALU_OR,  1,1,0,0,0,0,0,0}; // ori zero-ext
    vecs[6]  = '{32'h3026_F0F0, 1, 5'd6, 32'h0000_F0F0, ALU_AND, 1,1,0,0,0,0,0,0}; // andi zero-ext
    vecs[7]  = '{32'h3C07_1234, 1, 5'd7, 32'h1234_0000, ALU_LUI, 1,1,0,0,0,0,0,0}; // lui
    vecs[8]  = '{32'h8C28_FFFC, 1, 5'd8, 32'hFFFF_FFFC, ALU_ADD, 1,1,1,0,0,0,0,0}; // lw
    vecs[9]  = '{32'hAC28_0004, 1, 5'd0, 32'h0000_0004, ALU_ADD, 1,0,0,1,0,0,0,0}; // sw
    vecs[10] = '{32'h1022_FFFF, 1, 5'd0, 32'hFFFF_FFFF, ALU_SUB, 0,0,0,0,1,0,0,0}; // beq
    vecs[11] = '{32'h1422_0010, 1, 5'd0, 32'h0000_0010, ALU_SUB, 0,0,0,0,0,1,0,0}; // bne
    vecs[12] = '{32'h0800_0100, 1, 5'd0, 32'h0000_0100, ALU_ADD, 0,0,0,0,0,0,1,0}; // j
    vecs[13] = '{32'hFC00_0000, 1, 5'd0, 32'h0000_0000, ALU_ADD, 0,0,0,0,0,0,0,1}; // bad opcode
    vecs[14] = '{32'h0000_003F, 1, 5'd0, 32'h0000_003F, ALU_ADD, 0,0,0,0,0,0,0,1}; // bad funct
    vecs[15] = '{32'hFC00_0000, 0, 5'd0, 32'h0000_0000, ALU_ADD, 0,0,0,0,0,0,0,0}; // bad, not valid
    vecs[16] = '{32'h0000_0000, 1, 5'd0, 32'h0000_0000, ALU_SLL, 0,1,0,0,0,0,0,0}; // nop = sll
    vecs[17] = '{32'h8C28_FFFC, 0, 5'd8, 32'hFFFF_FFFC, ALU_ADD, 0,0,0,0,0,0,0,0}; // lw, not valid

    rst = 1'b1;
    inst_in = '0; pc_in = '0; in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    // ---- reset state ----
    #12;
    check("reset_bundle", dut_bundle(), 64'h0);
    check("reset_pc", {32'h0, id_pc}, 64'h0);
    check("reset_rsrt", {rs_data, rt_data}, 64'h0);
    @(negedge clk) rst = 1'b0;

    // ---- register file write / read, $0 stays zero ----
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_addr = 5'd0; wb_data = 32'h0000_1234;
    inst_in = 32'h0003_2020; pc_in = 32'h40; in_valid = 1'b1;
    @(negedge clk);
    wb_we = 1'b0;
    check("add_rt_data", {32'h0, rt_data}, {32'h0, 32'hDEAD_BEEF});
    check("add_rs_r0", {32'h0, rs_data}, 64'h0);
    check("add_dest", {59'h0, dest_addr}, 64'd4);

    // ---- decode table ----
    for (int i = 0; i < NVEC; i++) begin
      inst_in = vecs[i].inst; pc_in = 32'h100 + 32'(4 * i); in_valid = vecs[i].valid;
      @(negedge clk);
      check($sformatf("vec%0d_decode", i), dut_bundle(), vec_bundle(vecs[i]));
      check($sformatf("vec%0d_pc", i), {32'h0, id_pc}, {32'h0, 32'h100 + 32'(4 * i)});
    end

    // ---- flush wins over stall on a latched lw ----
    inst_in = 32'h8C28_FFFC; pc_in = 32'h180; in_valid = 1'b1;
    @(negedge clk);
    check("lw_mem_rd", {63'h0, mem_rd}, 64'd1);
    stall = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_valid_memrd", {62'h0, id_valid, mem_rd}, 64'd0);
    stall = 1'b0; flush = 1'b0;

    // ---- stall alone holds latch for 3 cycles ----
    inst_in = 32'h2009_FFFF; pc_in = 32'h200; in_valid = 1'b1;
    @(negedge clk);
    held = vecs[0].valid ? vec_bundle(vecs[0]) : 64'h0;
    check("pre_stall", dut_bundle(), held);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inst_in = 32'hAC28_0004 + 32'(k); pc_in = 32'h300 + 32'(k); in_valid = k[0];
      @(negedge clk);
      check($sformatf("stall%0d_decode", k), dut_bundle(), held);
      check($sformatf("stall%0d_pc", k), {32'h0, id_pc}, {32'h0, 32'h200});
    end
    stall = 1'b0;

    // ---- WB bypass: latched rs = 7, write to $7 while stalled ----
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_00AA;
    inst_in = 32'h20E1_0000; pc_in = 32'h240; in_valid = 1'b1;  // addi $1,$7,0
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    check("byp_old", {32'h0, rs_data}, {32'h0, 32'h0000_00AA});
    stall = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0055;
    #1;
`ifdef ID_WB_BYPASS_EN
    check("byp_same_cycle", {32'h0, rs_data}, {32'h0, 32'h0000_0055});
`else
    check("byp_same_cycle", {32'h0, rs_data}, {32'h0, 32'h0000_00AA});
`endif
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    check("byp_next_cycle", {32'h0, rs_data}, {32'h0, 32'h0000_0055});
    check("byp_stall_valid", {63'h0, id_valid}, 64'd1);
    stall = 1'b0;

    // ---- async reset mid-run ----
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0077;
    inst_in = 32'h20A1_0000; pc_in = 32'h300; in_valid = 1'b1;  // addi $1,$5,0
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    check("pre_rst_rs", {32'h0, rs_data}, {32'h0, 32'h0000_0077});
    check("pre_rst_valid_pc", {31'h0, id_valid, id_pc}, {31'h0, 1'b1, 32'h300});
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid_pc", {31'h0, id_valid, id_pc}, 64'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_r5_cleared", {32'h0, rs_data}, 64'h0);
    check("rst_after_valid", {63'h0, id_valid}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the instruction-fetch unit.
- Consumes the fetched 32-bit MIPS instruction word and its PC.
- Holds both in an IF/ID pipeline latch with stall/flush control.
- Decodes fields and control, reads a 32x32 register file (written back by the WB stage), and presents operands and control to the execute stage.

Parameters:
- NREG, 32, number of architectural registers (index width = log2(NREG) = 5).
- RESET_PC, 32'h0000_0000, value of the latched PC after reset.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst_in  in  32  instruction word from fetch.
- pc_in  in  32  PC of inst_in.
- in_valid  in  1  inst_in/pc_in carry a real instruction.
- stall  in  1  hold the IF/ID latch.
- flush  in  1  squash the latched instruction (branch/jump redirect).
- wb_we  in  1  register-file write enable.
- wb_addr  in  5  write index.
- wb_data  in  32  write data.
- id_valid  out  1  latched instruction is live.
- id_pc  out  32  latched PC.
- rs_addr, rt_addr  out  5  inst[25:21], inst[20:16].
- dest_addr  out  5  rd for R-type, rt for I-type loads/ALU-immediate, 0 otherwise.
- rs_data, rt_data  out  32  register-file read data.
- imm_ext  out  32  extended immediate.
- alu_op  out  4  ALU operation code (package enum).
- alu_src_imm  out  1  second ALU operand is imm_ext.
- reg_we  out  1  instruction writes dest_addr.
- mem_rd, mem_we  out  1  load / store.
- branch_eq, branch_ne, jump  out  1  control-flow class.
- illegal  out  1  unsupported opcode/funct while id_valid.

Behaviour:
- Reset (async): latch inst <= 32'h0 (NOP), latched PC <= RESET_PC, id_valid <= 0, all 32 registers <= 0. Every decoded output is then 0 except id_pc = RESET_PC; rs_data = rt_data = 0.
- Latch update per rising edge, priority order:
  - flush: id_valid <= 0, inst <= 0. Flush wins over stall.
  - else stall: hold all latch contents.
  - else: inst <= inst_in, pc <= pc_in, id_valid <= in_valid.
- Latency: one cycle from inst_in to decoded outputs. Decode and reads are combinational from the latch and register file.
- Register file:
  - Writes on rising edge when wb_we and wb_addr != 0.
  - Register 0 always reads 0.
  - Writes proceed during stall and flush.
- Supported R-type (op 0x00), funct: add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sll 00, srl 02.
- Supported I-type/J-type, op: addi 08, andi 0C, ori 0D, xori 0E, lui 0F, lw 23, sw 2B, beq 04, bne 05, j 02.
- Immediate extension: andi/ori/xori zero-extend; lui places imm in [31:16] with zeros below; all others sign-extend imm[15].
- Jump target is not computed here; the execute stage uses id_pc and inst.
- When id_valid = 0: reg_we, mem_rd, mem_we, branch_eq, branch_ne, jump and illegal all forced to 0. alu_op and data outputs are don't-care but deterministic.
- Unsupported encodings: illegal = 1 and all side-effect controls forced to 0 (treated as NOP).
- Instruction 32'h0 decodes as sll r0,r0,0: reg_we = 1, dest_addr = 0, no architectural effect.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: same-cycle write-through. If wb_we and wb_addr != 0 and wb_addr equals rs_addr (resp. rt_addr), rs_data (resp. rt_data) = wb_data combinationally.
- Undefined: reads return the stored value; the new value is visible from the cycle after the write.

Decomposition:
- Package id_pkg holds:
  - opcode and funct localparams;
  - alu_op enum: ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, LUI, with 4-bit encoding;
  - NOP instruction constant.
- One sub-module: id_regfile (32x32, 2 async read ports, 1 sync write port, r0 hardwired, optional bypass inside).

Test Plan:
- Reset mid-run: assert rst while id_valid = 1 -> id_valid = 0, id_pc = 0, register 5 reads 0, no clock edge needed.
- Latch 32'h2009_FFFF (addi $9,$0,-1), in_valid = 1 -> next cycle: id_valid = 1, dest_addr = 9, imm_ext = 32'hFFFF_FFFF, alu_op = ADD, alu_src_imm = 1, reg_we = 1.
- Write $3 = 32'hDEAD_BEEF via WB, then latch 32'h0003_2020 (add $4,$0,$3) -> rt_data = 32'hDEAD_BEEF, dest_addr = 4. Write to $0 with 32'h1234 -> $0 still reads 0.
- stall = 1 and flush = 1 together on a latched lw -> id_valid = 0, mem_rd = 0. stall alone for 3 cycles -> latch and outputs unchanged while inst_in changes.
- Latch 32'hFC00_0000 -> illegal = 1, reg_we = mem_we = 0. Same word with in_valid = 0 -> illegal = 0.
- Bypass: wb_we = 1, wb_addr = 7, wb_data = 32'h55, latched rs = 7 -> rs_data = 32'h55 same cycle with ID_WB_BYPASS_EN defined; old value without it, 32'h55 one cycle later.
